// File: rtl/apb_master_arb_pkg.sv
// Shared types and default sizing for the two-requester APB master.
//   state_t : APB master sequencer states (IDLE, SETUP, ACCESS)
//   req_t   : one register-access request at default widths
package apb_arb_pkg;

  localparam int unsigned NREQ_DEF   = 2;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus between the SPI control master and the SPI register slave.
//   master modport : drives PADDR/PWDATA/PWRITE/PSEL/PENABLE, samples PRDATA/PREADY/PSLVERR/IRQ
//   slave modport  : the mirror image
interface apb_master_arb_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              IRQ;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR, IRQ
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR, IRQ
  );
endinterface

// File: rtl/apb_master_arb_rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req      : request bits
//   advance  : commit the current grant as the new last_grant
//   grant    : one-hot grant, highest priority is the requester after last_grant
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant_idx;
  logic          found;

  // Scan offsets 1..NREQ from last_grant; the first requester hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!found && req[(32'(last_grant) + k) % NREQ]) begin
        found = 1'b1;
        grant[(32'(last_grant) + k) % NREQ] = 1'b1;
        grant_idx = IW'((32'(last_grant) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(NREQ - 1);
    end else if (advance && found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// response routing back to the owning requester.
//   clk, rst            : clock (also PCLK), synchronous active-high reset
//   req_valid/ready     : per-requester handshake, req_ready one-hot
//   req_write/addr/wdata: per-requester command
//   rsp_valid           : one-hot one-cycle completion pulse
//   rsp_rdata, rsp_err  : read data (0 for writes) and error, held until next response
//   apb                 : APB master side (PADDR..PENABLE out, PRDATA/PREADY/PSLVERR/IRQ in)
//   irq                 : IRQ registered once
// Optional: APB_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ           = NREQ_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  apb_master_arb_if.master             apb,
  output logic                         irq
);

  state_t            state, state_nx;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   owner;
  logic              accept;
  logic              done;
  logic              timeout;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // req_ready is gated by rst so it reads 0 while reset is held.
  always_comb begin
    state_nx    = state;
    req_ready   = '0;
    accept      = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready = grant;
          accept    = 1'b1;
          state_nx  = SETUP;
        end
      end
      SETUP: begin
        apb.PSEL = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        if (apb.PREADY || timeout) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign done = (state == ACCESS) && (apb.PREADY || timeout);

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i];
        sel_wdata = req_wdata[i];
      end
    end
  end

  // APB address/data/write hold their last values while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      apb.PADDR  <= '0;
      apb.PWDATA <= '0;
      apb.PWRITE <= 1'b0;
      owner      <= '0;
    end else if (accept) begin
      apb.PADDR  <= sel_addr;
      apb.PWDATA <= sel_wdata;
      apb.PWRITE <= sel_write;
      owner      <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (done) begin
        rsp_valid <= owner;
        rsp_err   <= timeout ? 1'b1 : apb.PSLVERR;
        rsp_rdata <= (apb.PWRITE || timeout) ? '0 : apb.PRDATA;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !apb.PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout = (state == ACCESS) && !apb.PREADY &&
                   (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // No abort path: ACCESS waits for PREADY indefinitely.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= apb.IRQ;
  end

endmodule

// File: tb/tb_apb_master_arb.sv
module tb_apb_master_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][4:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             irq;

  logic [31:0] prdata;
  logic        pslverr;
  logic        irq_in;
  logic        hold_ready;
  int          ws;
  int          wcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_master_arb_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  apb_master_arb #(
    .NREQ(2), .ADDR_W(5), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (bus.master),
    .irq       (irq)
  );

  // Slave model: ws wait states per ACCESS, or never ready while hold_ready.
  always @(posedge clk) begin
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
  end

  assign bus.PREADY  = hold_ready ? 1'b0 : (wcnt >= ws);
  assign bus.PRDATA  = prdata;
  assign bus.PSLVERR = pslverr;
  assign bus.IRQ     = irq_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    wcnt       = 0;
    ws         = 0;
    hold_ready = 1'b0;
    prdata     = 32'h0;
    pslverr    = 1'b0;
    irq_in     = 1'b0;
    req_valid  = 2'b00;
    req_write  = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    do_reset();

    check("rst_psel",    32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_paddr",   32'(bus.PADDR), 32'd0);
    check("rst_ready",   32'(req_ready), 32'd0);
    check("rst_rspv",    32'(rsp_valid), 32'd0);
    check("rst_irq",     32'(irq), 32'd0);

    // Single write from req0, zero wait states.
    req_valid    = 2'b01;
    req_write[0] = 1'b1;
    req_addr[0]  = 5'h04;
    req_wdata[0] = 32'hDEAD_BEEF;
    #1;
    check("w_ready_T", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    check("w_psel_T1",    32'(bus.PSEL), 32'd1);
    check("w_penable_T1", 32'(bus.PENABLE), 32'd0);
    check("w_paddr",      32'(bus.PADDR), 32'h04);
    check("w_pwdata",     bus.PWDATA, 32'hDEAD_BEEF);
    check("w_pwrite",     32'(bus.PWRITE), 32'd1);
    step();
    check("w_penable_T2", 32'(bus.PENABLE), 32'd1);
    check("w_rspv_T2",    32'(rsp_valid), 32'd0);
    step();
    check("w_rspv_T3",  32'(rsp_valid), 32'd1);
    check("w_err_T3",   32'(rsp_err), 32'd0);
    check("w_rdata_T3", rsp_rdata, 32'd0);
    check("w_psel_T3",  32'(bus.PSEL), 32'd0);
    step();
    check("w_rspv_T4", 32'(rsp_valid), 32'd0);
    check("w_paddr_hold", 32'(bus.PADDR), 32'h04);

    // Read from req1 with 2 wait states.
    ws           = 2;
    prdata       = 32'h1234_5678;
    req_valid    = 2'b10;
    req_write[1] = 1'b0;
    req_addr[1]  = 5'h10;
    #1;
    check("r_ready_T", 32'(req_ready), 32'd2);
    step();
    req_valid = 2'b00;
    check("r_pwrite", 32'(bus.PWRITE), 32'd0);
    step();
    step();
    step();
    check("r_penable_T4", 32'(bus.PENABLE), 32'd1);
    check("r_rspv_T4",    32'(rsp_valid), 32'd0);
    step();
    check("r_rspv_T5",  32'(rsp_valid), 32'd2);
    check("r_rdata_T5", rsp_rdata, 32'h1234_5678);
    ws = 0;

    // Reset clears held response data and the arbiter pointer.
    do_reset();
    check("rst2_rdata", rsp_rdata, 32'd0);
    check("rst2_pwrite", 32'(bus.PWRITE), 32'd0);

    // Both requesters continuously asserted: grants alternate 0,1,0,1.
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {5'h02, 5'h01};
    #1;
    check("rr_ready_0", 32'(req_ready), 32'(rr_exp[0]));
    for (int k = 0; k < 4; k++) begin
      prdata = 32'hA0 + 32'(k);
      step();
      step();
      step();
      check($sformatf("rr_rspv_%0d", k), 32'(rsp_valid), 32'(rr_exp[k]));
      check($sformatf("rr_rdata_%0d", k), rsp_rdata, 32'hA0 + 32'(k));
      if (k < 3) check($sformatf("rr_ready_%0d", k + 1), 32'(req_ready), 32'(rr_exp[k + 1]));
    end
    req_valid = 2'b00;
    step();

    // PSLVERR on a write, then a clean write.
    pslverr      = 1'b1;
    req_valid    = 2'b01;
    req_write[0] = 1'b1;
    step();
    req_valid = 2'b00;
    step();
    step();
    check("err_rspv", 32'(rsp_valid), 32'd1);
    check("err_flag", 32'(rsp_err), 32'd1);
    step();
    check("err_hold", 32'(rsp_err), 32'd1);
    pslverr      = 1'b0;
    req_valid    = 2'b10;
    req_write[1] = 1'b1;
    step();
    req_valid = 2'b00;
    step();
    step();
    check("ok_rspv", 32'(rsp_valid), 32'd2);
    check("ok_flag", 32'(rsp_err), 32'd0);
    step();

    // Reset during ACCESS discards the transfer.
    hold_ready = 1'b1;
    req_valid  = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    check("mid_in_access", 32'(bus.PENABLE), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_psel",    32'(bus.PSEL), 32'd0);
    check("mid_penable", 32'(bus.PENABLE), 32'd0);
    hold_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_norsp_%0d", k), 32'(rsp_valid), 32'd0);
      step();
    end
    req_valid    = 2'b01;
    req_write[0] = 1'b0;
    prdata       = 32'h0BAD_F00D;
    #1;
    check("mid_next_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    step();
    step();
    check("mid_next_rspv",  32'(rsp_valid), 32'd1);
    check("mid_next_rdata", rsp_rdata, 32'h0BAD_F00D);
    step();

    // IRQ registered once.
    irq_in = 1'b1;
    #1;
    check("irq_pre", 32'(irq), 32'd0);
    step();
    check("irq_set", 32'(irq), 32'd1);
    irq_in = 1'b0;
    step();
    check("irq_clr", 32'(irq), 32'd0);

`ifdef APB_TIMEOUT_EN
    begin
      int acc_cycles;
      acc_cycles = 0;
      hold_ready = 1'b1;
      prdata     = 32'hFFFF_FFFF;
      req_valid  = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      for (int k = 0; k < 40; k++) begin
        if (!bus.PENABLE) break;
        acc_cycles++;
        step();
      end
      check("to_access_cycles", 32'(acc_cycles), 32'd16);
      check("to_rspv",  32'(rsp_valid), 32'd1);
      check("to_err",   32'(rsp_err), 32'd1);
      check("to_rdata", rsp_rdata, 32'd0);
      check("to_psel",  32'(bus.PSEL), 32'd0);
      hold_ready = 1'b0;
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
